// File: rtl/uart_pkg.sv
// Shared UART definitions: line levels, frame constants, state encodings, bit timing.
// State PARITY is only reachable when SERIALIZE_PARITY_EN is defined.
package uart_pkg;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam int unsigned DATA_BITS = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // A zero baud rate yields 0 so unconfigured instances do not divide by zero.
    function automatic int unsigned bit_cycles(input int unsigned src_clock,
                                               input int unsigned bauds);
        return (bauds == 0) ? 0 : src_clock / bauds;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Restartable baud counter: counts 0..CYCLES-1 and flags the last cycle of each bit.
// Shared between the UART transmitter and deserializer.
module uart_baud_tick #(
    parameter int unsigned CYCLES = 2,
    parameter int unsigned CNT_W  = $clog2(CYCLES + 1)
) (
    input  logic ser_ck,
    input  logic rst,
    input  logic restart,
    output logic bit_end
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        bit_end = (cnt_q == CNT_W'(CYCLES - 1));
        cnt_d   = (restart || bit_end) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge ser_ck) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serialize_shifter_tx.sv
// 8N1 UART transmitter with a one-byte holding register for gap-free back-to-back frames.
// Define SERIALIZE_PARITY_EN for 8E1 framing (even parity bit after the data bits).
module serialize_shifter_tx
    import uart_pkg::*;
#(
    parameter int unsigned SRC_CLOCK = 0,
    parameter int unsigned BAUDS     = 0
) (
    input  logic       ser_ck,
    input  logic       rst,
    input  logic       wr_data,
    input  logic [7:0] data_in,
    output logic       serout,
    output logic       ready,
    output logic       busy
);

    localparam int unsigned BIT_CYCLES = bit_cycles(SRC_CLOCK, BAUDS);
    // Unconfigured defaults still elaborate (for standalone lint); any real override must be >= 2.
    localparam int unsigned TICK_CYCLES = (BIT_CYCLES < 2) ? 2 : BIT_CYCLES;

    if (BIT_CYCLES < 2 && (SRC_CLOCK != 0 || BAUDS != 0)) begin : g_bad_timing
        $error("serialize_shifter_tx: SRC_CLOCK/BAUDS must give at least 2 cycles per bit");
    end

    logic [2:0] state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_valid_q, hold_valid_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       serout_q, serout_d;
    logic       busy_q, busy_d;
    logic       ready_q, ready_d;

    logic       bit_end;
    logic       restart;
    logic       load;
    logic [2:0] next_idx;

    uart_baud_tick #(
        .CYCLES (TICK_CYCLES),
        .CNT_W  ($clog2(TICK_CYCLES + 1))
    ) u_baud_tick (
        .ser_ck  (ser_ck),
        .rst     (rst),
        .restart (restart),
        .bit_end (bit_end)
    );

    assign restart = (state_q == ST_IDLE);
    assign next_idx = bit_idx_q + 3'd1;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        serout_d     = serout_q;
        busy_d       = busy_q;
        load         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                serout_d = IDLE_LEVEL;
                load     = hold_valid_q;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    serout_d  = shift_q[0];
                    bit_idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef SERIALIZE_PARITY_EN
                        state_d  = ST_PARITY;
                        serout_d = ^shift_q;
`else
                        state_d  = ST_STOP;
                        serout_d = IDLE_LEVEL;
`endif
                    end else begin
                        bit_idx_d = next_idx;
                        serout_d  = shift_q[next_idx];
                    end
                end
            end
`ifdef SERIALIZE_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d  = ST_STOP;
                    serout_d = IDLE_LEVEL;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (hold_valid_q) begin
                        load = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        busy_d   = 1'b0;
                        serout_d = IDLE_LEVEL;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                serout_d = IDLE_LEVEL;
                busy_d   = 1'b0;
            end
        endcase

        // A load and an accepted write never coincide: ready_q=1 implies the holder is empty.
        if (load) begin
            shift_d      = hold_q;
            hold_valid_d = 1'b0;
            serout_d     = START_LEVEL;
            state_d      = ST_START;
            busy_d       = 1'b1;
        end

        if (wr_data && ready_q) begin
            hold_d       = data_in;
            hold_valid_d = 1'b1;
        end

        ready_d = !hold_valid_d;
    end

    always_ff @(posedge ser_ck) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            serout_q     <= IDLE_LEVEL;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            serout_q     <= serout_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
        end
    end

    assign serout = serout_q;
    assign ready  = ready_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_serialize_shifter_tx.sv
// Self-checking bench for serialize_shifter_tx: timing reference model feeds a frame scoreboard.
// Build with SERIALIZE_PARITY_EN defined to exercise 8E1 framing.
module tb_serialize_shifter_tx;

    localparam int unsigned BC = 16;
`ifdef SERIALIZE_PARITY_EN
    localparam int unsigned NB = 11;
`else
    localparam int unsigned NB = 10;
`endif
    localparam int unsigned FRAME = NB * BC;

    typedef struct {
        logic [7:0]  data;
        int unsigned cyc;
    } exp_t;

    logic       ser_ck = 1'b0;
    logic       rst = 1'b1;
    logic       wr_data = 1'b0;
    logic [7:0] data_in = '0;
    logic       serout, ready, busy;

    int unsigned errors = 0;
    int unsigned checks = 0;

    exp_t        sb[$];
    int unsigned cyc = 0;
    logic        chk_en = 1'b0;

    logic        m_hv = 1'b0;
    logic [7:0]  m_hold = '0;
    int unsigned m_rem = 0;

    logic        mon_busy = 1'b0;
    int unsigned mon_start = 0;
    int unsigned mon_off;
    logic [10:0] mon_bits = '0;
    exp_t        mon_e;

    serialize_shifter_tx #(
        .SRC_CLOCK (16),
        .BAUDS     (1)
    ) dut (
        .ser_ck  (ser_ck),
        .rst     (rst),
        .wr_data (wr_data),
        .data_in (data_in),
        .serout  (serout),
        .ready   (ready),
        .busy    (busy)
    );

    always #5 ser_ck = ~ser_ck;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Reference timing model: holder plus remaining-cycles-in-frame counter.
    always @(posedge ser_ck) begin
        logic old_hv;
        cyc++;
        if (rst) begin
            m_hv  = 1'b0;
            m_rem = 0;
            sb.delete();
        end else begin
            old_hv = m_hv;
            if (m_hv && (m_rem <= 1)) begin
                sb.push_back('{data: m_hold, cyc: cyc});
                m_rem = FRAME;
                m_hv  = 1'b0;
            end else if (m_rem > 0) begin
                m_rem--;
            end
            if (wr_data && !old_hv) begin
                m_hv   = 1'b1;
                m_hold = data_in;
            end
        end
    end

    always @(negedge ser_ck) begin
        if (chk_en) begin
            check_eq("ready", ready, !m_hv);
            check_eq("busy", busy, m_rem != 0);
            if (m_rem == 0) check_eq("idle_line", serout, 1'b1);
        end
    end

    // Frame monitor: decodes the line mid-bit and pops the scoreboard at the stop bit.
    always @(negedge ser_ck) begin
        if (chk_en) begin
            if (rst) begin
                mon_busy = 1'b0;
            end else if (!mon_busy) begin
                if (serout == 1'b0) begin
                    mon_busy  = 1'b1;
                    mon_start = cyc;
                    mon_bits  = '0;
                end
            end else begin
                mon_off = cyc - mon_start;
                if (mon_off % BC == BC / 2) begin
                    mon_bits[mon_off / BC] = serout;
                    if (mon_off / BC == NB - 1) begin
                        mon_busy = 1'b0;
                        check_eq("start_bit", mon_bits[0], 1'b0);
                        check_eq("stop_bit", mon_bits[NB-1], 1'b1);
                        check_eq("sb_nonempty", sb.size() != 0, 1'b1);
                        if (sb.size() != 0) begin
                            mon_e = sb.pop_front();
                            check_eq("start_cyc", mon_start, mon_e.cyc);
                            check_eq("data", mon_bits[8:1], mon_e.data);
`ifdef SERIALIZE_PARITY_EN
                            check_eq("parity", mon_bits[9], ^mon_e.data);
`endif
                        end
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(posedge ser_ck);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        wr_data = 1'b1;
        data_in = b;
        @(posedge ser_ck);
        #1;
        wr_data = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        chk_en = 1'b1;
        wait_cyc(50);

        wr_byte(8'h55);
        wait_cyc(200);

        wr_byte(8'hA3);
        wait_cyc(5);
        wr_byte(8'h0F);
        wait_cyc(3);
        wr_byte(8'h33);
        wait_cyc(400);

        // Reset lands during data bit 4 of 0xFF; the queued 0x12 must never appear.
        wr_byte(8'hFF);
        wait_cyc(3);
        wr_byte(8'h12);
        wait_cyc(84);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(300);

        wr_byte(8'h07);
        wait_cyc(200);
        wr_byte(8'h03);
        wait_cyc(200);

        wr_data = 1'b1;
        data_in = 8'h80;
        wait_cyc(400);
        wr_data = 1'b0;

        for (int i = 0; i < 3000 && (sb.size() != 0 || m_rem != 0 || m_hv); i++) begin
            wait_cyc(1);
        end
        wait_cyc(20);
        check_eq("sb_empty", sb.size(), 0);
        check_eq("mon_idle", mon_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
